uart_cfg_master: RTL and testbench

UART_CFG_MASTER -- requirements
Module: uart_cfg_master

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_timeout_cnt.sv | 21 ++
 rtl/uart_cfg_master.sv | 120 ++++++++++++
 tb/tb_uart_cfg_master.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: register map, error codes, FSM states and config record shared by the UART config master.
package uart_pkg;
   localparam logic [2:0] REG_PARITY      = 3'd0;
   localparam logic [2:0] REG_PARITY_TYPE = 3'd1;
   localparam logic [2:0] REG_STOP_BITS   = 3'd2;
   localparam logic [2:0] REG_FRAME_LEN   = 3'd3;
   localparam int         RD_BIT          = 3;
   localparam logic [1:0] ERR_OK          = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT     = 2'b01;
   localparam logic [1:0] ERR_MISMATCH    = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE, S_WR, S_WR_WAIT, S_GAP, S_RD, S_RD_WAIT, S_FINISH
   } state_e;

   typedef struct packed {
      logic       parity;
      logic       parity_type;
      logic       stop_bits;
      logic [3:0] frame_length;
   } cfg_t;

   function automatic logic [3:0] reg_value(cfg_t c, logic [2:0] idx);
      return idx == REG_PARITY      ? {3'b000, c.parity} :
             idx == REG_PARITY_TYPE ? {3'b000, c.parity_type} :
             idx == REG_STOP_BITS   ? {3'b000, c.stop_bits} :
                                      c.frame_length;
   endfunction
endpackage

// File: rtl/uart_timeout_cnt.sv
// uart_timeout_cnt: per-transaction wait timer; reads 0 the cycle after clear and saturates at TIMEOUT.
module uart_timeout_cnt #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic expired
);
   localparam int W = $clog2(TIMEOUT + 1);
   logic [W-1:0] cnt_q, cnt_d;

   assign expired = (cnt_q == W'(TIMEOUT));

   always_comb cnt_d = clear ? '0 : (expired ? cnt_q : cnt_q + 1'b1);

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/uart_cfg_master.sv
// uart_cfg_master: writes the four UART config registers, reads them back and reports
// timeout or read-back mismatch.
module uart_cfg_master
   import uart_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       cfg_parity,
   input  logic       cfg_parity_type,
   input  logic       cfg_stop_bits,
   input  logic [3:0] cfg_frame_length,
   output logic       valid,
   output logic [3:0] address,
   output logic [3:0] data,
   input  logic       ack,
   input  logic       data_out_valid,
   input  logic [3:0] data_in,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [1:0] err_code
);
   state_e     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic       rd_q, rd_d;
   cfg_t       cfg_q, cfg_d;
   logic       error_q, error_d;
   logic [1:0] err_code_q, err_code_d;
   logic [3:0] cur_val;
   logic       tmr_clear, tmr_expired;

   assign cur_val   = reg_value(cfg_q, {1'b0, idx_q});
   assign tmr_clear = (state_d == S_WR) || (state_d == S_RD);

   uart_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (tmr_clear),
      .expired (tmr_expired)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      rd_d       = rd_q;
      cfg_d      = cfg_q;
      error_d    = error_q;
      err_code_d = err_code_q;
      case (state_q)
         S_IDLE: if (start) begin
            state_d    = S_WR;
            idx_d      = 2'd0;
            rd_d       = 1'b0;
            cfg_d      = {cfg_parity, cfg_parity_type, cfg_stop_bits, cfg_frame_length};
            error_d    = 1'b0;
            err_code_d = ERR_OK;
         end
         S_WR: state_d = S_WR_WAIT;
         S_RD: state_d = S_RD_WAIT;
         // A response on the expiring cycle takes precedence over the timeout.
         S_WR_WAIT: if (ack) state_d = S_GAP;
            else if (tmr_expired) begin
               state_d    = S_FINISH;
               error_d    = 1'b1;
               err_code_d = ERR_TIMEOUT;
            end
         S_RD_WAIT: if (data_out_valid) begin
               state_d = (data_in == cur_val) ? S_GAP : S_FINISH;
               if (data_in != cur_val) begin
                  error_d    = 1'b1;
                  err_code_d = ERR_MISMATCH;
               end
            end else if (tmr_expired) begin
               state_d    = S_FINISH;
               error_d    = 1'b1;
               err_code_d = ERR_TIMEOUT;
            end
         S_GAP: if (idx_q != 2'd3) begin
               idx_d   = idx_q + 2'd1;
               state_d = rd_q ? S_RD : S_WR;
            end else if (!rd_q) begin
               idx_d   = 2'd0;
               rd_d    = 1'b1;
               state_d = S_RD;
            end else state_d = S_FINISH;
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= 2'd0;
         rd_q       <= 1'b0;
         cfg_q      <= '0;
         error_q    <= 1'b0;
         err_code_q <= ERR_OK;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         rd_q       <= rd_d;
         cfg_q      <= cfg_d;
         error_q    <= error_d;
         err_code_q <= err_code_d;
      end
   end

   assign valid    = (state_q == S_WR) || (state_q == S_WR_WAIT) ||
                     (state_q == S_RD) || (state_q == S_RD_WAIT);
   assign address  = valid ? {rd_q, 1'b0, idx_q} : 4'h0;
   assign data     = (valid && !rd_q) ? cur_val : 4'h0;
   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_FINISH);
   assign error    = error_q;
   assign err_code = err_code_q;
endmodule

// File: tb/tb_uart_cfg_master.sv
// tb_uart_cfg_master: randomized responder plus a per-cycle expected-output trace built
// from the transaction plan, with directed scenarios pinning the trace model.
module tb_uart_cfg_master;
   localparam int TIMEOUT = 15;

   logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic       cfg_parity = 1'b0, cfg_parity_type = 1'b0, cfg_stop_bits = 1'b0;
   logic [3:0] cfg_frame_length = 4'h0;
   logic       valid, busy, done, error;
   logic [3:0] address, data;
   logic       ack = 1'b0, data_out_valid = 1'b0;
   logic [3:0] data_in = 4'h0;
   logic [1:0] err_code;

   int n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   uart_cfg_master #(.TIMEOUT(TIMEOUT)) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .cfg_parity       (cfg_parity),
      .cfg_parity_type  (cfg_parity_type),
      .cfg_stop_bits    (cfg_stop_bits),
      .cfg_frame_length (cfg_frame_length),
      .valid            (valid),
      .address          (address),
      .data             (data),
      .ack              (ack),
      .data_out_valid   (data_out_valid),
      .data_in          (data_in),
      .busy             (busy),
      .done             (done),
      .error            (error),
      .err_code         (err_code)
   );

   typedef struct packed {
      logic       valid;
      logic [3:0] address;
      logic [3:0] data;
      logic       busy;
      logic       done;
      logic       error;
      logic [1:0] err_code;
   } obs_t;

   obs_t       exp_q[$];
   logic       hold_err = 1'b0;
   logic [1:0] hold_code = 2'b00;
   bit         chk_en = 0;

   int         plan_d[8];
   logic [3:0] plan_x[8];
   bit         stray_en = 0;
   int         resp_txn = -1, resp_cnt = 0, done_cnt = 0;
   bit         prev_valid = 0;
   logic [3:0] regs[4];
   logic [3:0] addr_log[$], wdata_log[$];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [3:0] spec_val(input logic [6:0] c, input int i);
      return i == 0 ? {3'b000, c[6]} : i == 1 ? {3'b000, c[5]} : i == 2 ? {3'b000, c[4]} : c[3:0];
   endfunction

   task automatic push_finish(input logic [1:0] code);
      exp_q.push_back({1'b0, 4'h0, 4'h0, 1'b1, 1'b1, code != 2'b00, code});
   endtask

   // One entry per cycle from the cycle after start is sampled through FINISH.
   task automatic build_trace(input logic [6:0] c);
      obs_t v;
      bit   rd;
      int   i, n;
      for (int k = 0; k < 8; k++) begin
         rd = (k >= 4);
         i  = k % 4;
         v  = {1'b1, rd, 1'b0, 2'(i), rd ? 4'h0 : spec_val(c, i), 1'b1, 1'b0, 1'b0, 2'b00};
         n  = (plan_d[k] == 0) ? TIMEOUT + 1 : plan_d[k] + 1;
         repeat (n) exp_q.push_back(v);
         if (plan_d[k] == 0) begin
            push_finish(2'b01);
            return;
         end
         if (rd && plan_x[k] != 4'h0) begin
            push_finish(2'b10);
            return;
         end
         exp_q.push_back({1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 2'b00});
      end
      push_finish(2'b00);
   endtask

   always @(negedge clk) begin
      obs_t act, e;
      if (chk_en) begin
         act = {valid, address, data, busy, done, error, err_code};
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.done) begin
               hold_err  = e.error;
               hold_code = e.err_code;
            end
         end else e = {1'b0, 4'h0, 4'h0, 1'b0, 1'b0, hold_err, hold_code};
         chk("cycle", int'(act), int'(e));
         if (done) done_cnt++;
      end
   end

   // Register-file responder: answers transaction k on its plan_d[k]-th wait cycle.
   always @(negedge clk) begin
      ack = 1'b0;
      data_out_valid = 1'b0;
      data_in = 4'($urandom);
      if (valid) begin
         if (!prev_valid) begin
            resp_txn++;
            resp_cnt = 0;
            addr_log.push_back(address);
            if (!address[3]) wdata_log.push_back(data);
         end else resp_cnt++;
         if (resp_txn >= 0 && resp_txn < 8 && plan_d[resp_txn] == resp_cnt) begin
            if (address[3]) begin
               data_out_valid = 1'b1;
               data_in = regs[address[1:0]] ^ plan_x[resp_txn];
            end else begin
               ack = 1'b1;
               regs[address[1:0]] = data;
            end
         end
      end else if (stray_en && $urandom_range(0, 2) == 0) begin
         ack = 1'b1;
         data_out_valid = 1'b1;
      end
      prev_valid = valid;
   end

   task automatic set_plan(input int d);
      for (int k = 0; k < 8; k++) begin
         plan_d[k] = d;
         plan_x[k] = 4'h0;
      end
   endtask

   task automatic begin_seq(input logic [6:0] c, output int qn);
      @(negedge clk);
      #1;
      {cfg_parity, cfg_parity_type, cfg_stop_bits, cfg_frame_length} = c;
      resp_txn = -1;
      addr_log.delete();
      wdata_log.delete();
      done_cnt = 0;
      start = 1'b1;
      @(posedge clk);
      build_trace(c);
      qn = exp_q.size();
      #1 start = 1'b0;
   endtask

   task automatic run_seq(input logic [6:0] c, input bit busy_start, output int qn);
      int cyc;
      begin_seq(c, qn);
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 400) begin
         @(negedge clk);
         #1;
         cyc++;
         start = busy_start && exp_q.size() > 3 && $urandom_range(0, 3) == 0;
         if (busy_start) {cfg_parity, cfg_parity_type, cfg_stop_bits, cfg_frame_length} = 7'($urandom);
      end
      chk("drain", exp_q.size(), 0);
      start = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   int qn, cyc;
   int exp_addr[8] = '{0, 1, 2, 3, 8, 9, 10, 11};
   int exp_wd[4]   = '{1, 0, 1, 8};

   initial begin
      set_plan(2);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("reset outputs", {valid, address, data, busy, done, error, err_code}, 0);
      rst = 1'b0;
      chk_en = 1;

      // Basic sequence with 2-cycle responses.
      set_plan(2);
      run_seq({1'b1, 1'b0, 1'b1, 4'd8}, 0, qn);
      chk("basic trace len", qn, 33);
      chk("basic txn count", addr_log.size(), 8);
      for (int k = 0; k < 8 && k < addr_log.size(); k++) chk("basic addr", addr_log[k], exp_addr[k]);
      for (int k = 0; k < 4 && k < wdata_log.size(); k++) chk("basic wdata", wdata_log[k], exp_wd[k]);
      chk("basic done pulses", done_cnt, 1);
      chk("basic err_code", err_code, 0);

      // Write 2 never acknowledged.
      set_plan(2);
      plan_d[2] = 0;
      run_seq({1'b1, 1'b0, 1'b1, 4'd8}, 0, qn);
      chk("timeout trace len", qn, 25);
      chk("timeout txn count", addr_log.size(), 3);
      chk("timeout error", error, 1);
      chk("timeout err_code", err_code, 1);
      chk("timeout done pulses", done_cnt, 1);

      // Read of register 3 returns 7 instead of 8.
      set_plan(2);
      plan_x[7] = 4'hF;
      run_seq({1'b1, 1'b0, 1'b1, 4'd8}, 0, qn);
      chk("mismatch trace len", qn, 32);
      chk("mismatch txn count", addr_log.size(), 8);
      chk("mismatch err_code", err_code, 2);
      chk("mismatch done pulses", done_cnt, 1);

      // Reset (together with start) during WR_WAIT of index 1.
      set_plan(3);
      begin_seq({1'b0, 1'b1, 1'b1, 4'd5}, qn);
      cyc = 0;
      while (!(resp_txn == 1 && resp_cnt == 1) && cyc < 100) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      chk("reset reach WR_WAIT1", cyc < 100, 1);
      rst = 1'b1;
      start = 1'b1;
      @(posedge clk);
      exp_q.delete();
      hold_err = 1'b0;
      hold_code = 2'b00;
      @(negedge clk);
      #1;
      chk("mid reset outputs", {valid, address, data, busy, done, error, err_code}, 0);
      rst = 1'b0;
      start = 1'b0;
      run_seq({1'b0, 1'b1, 1'b1, 4'd5}, 0, qn);
      chk("post reset first addr", addr_log.size() > 0 ? int'(addr_log[0]) : -1, 0);
      chk("post reset txn count", addr_log.size(), 8);
      chk("post reset err_code", err_code, 0);

      // Responses on exactly the TIMEOUT-th wait cycle.
      set_plan(TIMEOUT);
      run_seq({1'b0, 1'b0, 1'b0, 4'd15}, 0, qn);
      chk("edge trace len", qn, 137);
      chk("edge txn count", addr_log.size(), 8);
      chk("edge error", error, 0);

      // Stray strobes while idle/gap and start pulses while busy.
      set_plan(2);
      stray_en = 1;
      run_seq({1'b1, 1'b1, 1'b0, 4'd9}, 1, qn);
      chk("stray txn count", addr_log.size(), 8);
      chk("stray err_code", err_code, 0);
      chk("stray done pulses", done_cnt, 1);

      for (int s = 0; s < 30; s++) begin
         for (int k = 0; k < 8; k++) begin
            plan_d[k] = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
            plan_x[k] = (k >= 4 && $urandom_range(0, 11) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         end
         stray_en = $urandom_range(0, 1) == 1;
         run_seq(7'($urandom), $urandom_range(0, 1) == 1, qn);
         chk("random done pulses", done_cnt, 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
